add2_seq_ctrl: RTL and testbench

Multi-cycle sequencer that adds two WIDTH-bit operands through a single 2-bit adder slice with carry, one 2-bit digit per clock, LSB digit first. Wraps the 2-bit adder datapath for wider arithmetic in the combinational/sequential teaching projects. Uses a start/ready request and a done/ack completion handshake. The result is held stable until the next operation is accepted.

---
 rtl/add2_seq_ctrl_if.sv | 34 +++
 rtl/add2_seq_ctrl.sv | 100 ++++++++++
 tb/tb_add2_seq_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/add2_seq_ctrl_if.sv
// Request/completion handshake bundle for the 2-bit-slice sequential adder.
// Carries the sub select only when ADD2_SEQ_SUB_EN is defined.
interface add2_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
`ifdef ADD2_SEQ_SUB_EN
    logic             sub;
`endif
    logic             ack;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, opA, opB, ack,
`ifdef ADD2_SEQ_SUB_EN
        output sub,
`endif
        input  ready, busy, done, sum, cout
    );

    modport slave (
        input  start, opA, opB, ack,
`ifdef ADD2_SEQ_SUB_EN
        input  sub,
`endif
        output ready, busy, done, sum, cout
    );
endinterface

// File: rtl/add2_seq_ctrl.sv
// Adds two WIDTH-bit operands one 2-bit digit per clock, LSB digit first.
// Define ADD2_SEQ_SUB_EN to add a sub input (opA - opB via ~opB and carry-in 1).
//
// state | meaning
// IDLE  | ready for a new request, last result held on sum/cout
// RUN   | one 2-bit slice per edge, counter selects the digit
// DONE  | result valid, waiting for ack
module add2_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rstN,
    add2_seq_ctrl_if.slave bus
);
    localparam int DIGITS = WIDTH / 2;
    localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic [CW-1:0]    cnt_q;
    logic [CW:0]      base;
    logic [2:0]       slice;
    logic             last;

    assign base = {cnt_q, 1'b0};
    assign last = (cnt_q == CW'(DIGITS - 1));

    always_comb begin
        slice   = {1'b0, a_q[base +: 2]} + {1'b0, b_q[base +: 2]} + {2'b00, carry_q};
        acc_nxt = acc_q;
        acc_nxt[base +: 2] = slice[1:0];
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q   <= bus.opA;
                        acc_q <= '0;
                        cnt_q <= '0;
`ifdef ADD2_SEQ_SUB_EN
                        b_q     <= bus.sub ? ~bus.opB : bus.opB;
                        carry_q <= bus.sub;
`else
                        b_q     <= bus.opB;
                        carry_q <= 1'b0;
`endif
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc_q   <= acc_nxt;
                    carry_q <= slice[2];
                    // Counter parks on the last digit rather than wrapping.
                    if (last) begin
                        sum_q  <= acc_nxt;
                        cout_q <= slice[2];
                        state  <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready = (state == IDLE);
    assign bus.busy  = (state == RUN);
    assign bus.done  = (state == DONE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
endmodule

// File: tb/tb_add2_seq_ctrl.sv
// Scoreboard bench for add2_seq_ctrl: stimulus queues expected {cout,sum},
// a monitor pops and compares each time done rises.
module tb_add2_seq_ctrl;
    localparam int WIDTH  = 8;
    localparam int DIGITS = WIDTH / 2;

    logic clk  = 1'b0;
    logic rstN = 1'b1;

    add2_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    add2_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [WIDTH:0] sb[$];
    logic done_prev = 1'b0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (!rstN) begin
            done_prev = 1'b0;
        end else begin
            if (bus.done && !done_prev) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_done", 32'(bus.done), 32'd0);
                end else begin
                    chk("sb_result", 32'({bus.cout, bus.sum}), 32'(sb.pop_front()));
                end
            end
            done_prev = bus.done;
        end
    end

    task automatic drive_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit s);
        bus.opA = a;
        bus.opB = b;
`ifdef ADD2_SEQ_SUB_EN
        bus.sub = s;
`else
        if (s) $display("note: sub request ignored in add-only build");
`endif
    endtask

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input bit s, input logic [WIDTH:0] exp);
        @(negedge clk);
        drive_op(a, b, s);
        bus.start = 1'b1;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.opA   = WIDTH'($urandom);
        bus.opB   = WIDTH'($urandom);
    endtask

    task automatic expect_run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("run_flags", 32'({bus.busy, bus.done, bus.ready}), 32'b100);
        end
        @(negedge clk);
        chk("done_flags", 32'({bus.busy, bus.done, bus.ready}), 32'b010);
    endtask

    task automatic hold(input int n, input logic [WIDTH:0] exp);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("hold_flags", 32'({bus.busy, bus.done, bus.ready}), 32'b010);
            chk("hold_result", 32'({bus.cout, bus.sum}), 32'(exp));
        end
    endtask

    task automatic release_op(input bit with_start, input logic [WIDTH:0] exp);
        @(negedge clk);
        bus.ack = 1'b1;
        if (with_start) begin
            drive_op(8'h01, 8'h01, 1'b0);
            bus.start = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.ack   = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk("idle_flags", 32'({bus.busy, bus.done, bus.ready}), 32'b001);
        chk("idle_result", 32'({bus.cout, bus.sum}), 32'(exp));
        @(negedge clk);
        chk("idle_stays", 32'({bus.busy, bus.done, bus.ready}), 32'b001);
    endtask

    initial begin
        bus.start = 1'b1;
        bus.ack   = 1'b1;
        drive_op(WIDTH'($urandom), WIDTH'($urandom), 1'b0);
        #1 rstN = 1'b0;
        #1;
        chk("reset_flags", 32'({bus.busy, bus.done, bus.ready}), 32'b001);
        chk("reset_result", 32'({bus.cout, bus.sum}), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.ack   = 1'b0;
        rstN      = 1'b1;

        // ack while idle has no effect
        @(negedge clk);
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        chk("ack_in_idle", 32'({bus.busy, bus.done, bus.ready}), 32'b001);

        issue(8'h5A, 8'h33, 1'b0, 9'h08D);
        expect_run(DIGITS);
        hold(5, 9'h08D);
        release_op(1'b0, 9'h08D);

        issue(8'hFF, 8'h01, 1'b0, 9'h100);
        expect_run(DIGITS);
        release_op(1'b0, 9'h100);

        issue(8'hAA, 8'h55, 1'b0, 9'h0FF);
        expect_run(DIGITS);
        release_op(1'b0, 9'h0FF);

        // start during RUN must be ignored
        issue(8'h11, 8'h22, 1'b0, 9'h033);
        @(negedge clk);
        chk("run_flags", 32'({bus.busy, bus.done, bus.ready}), 32'b100);
        drive_op(8'hFF, 8'hFF, 1'b0);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        expect_run(DIGITS - 1);
        release_op(1'b1, 9'h033);

        issue(8'h21, 8'h13, 1'b0, 9'h034);
        expect_run(DIGITS);
        release_op(1'b0, 9'h034);

        // reset mid-RUN drops the operation
        issue(8'hC3, 8'h3C, 1'b0, 9'h0FF);
        @(posedge clk);
        #2 rstN = 1'b0;
        #1;
        sb.delete();
        chk("midrun_reset_flags", 32'({bus.busy, bus.done, bus.ready}), 32'b001);
        chk("midrun_reset_result", 32'({bus.cout, bus.sum}), 32'd0);
        @(negedge clk);
        rstN = 1'b1;

        issue(8'h12, 8'h34, 1'b0, 9'h046);
        expect_run(DIGITS);
        release_op(1'b0, 9'h046);

        issue(8'h80, 8'h80, 1'b0, 9'h100);
        expect_run(DIGITS);
        release_op(1'b0, 9'h100);

`ifdef ADD2_SEQ_SUB_EN
        issue(8'h10, 8'h01, 1'b1, 9'h10F);
        expect_run(DIGITS);
        release_op(1'b0, 9'h10F);

        issue(8'h01, 8'h02, 1'b1, 9'h0FF);
        expect_run(DIGITS);
        release_op(1'b0, 9'h0FF);

        issue(8'h5A, 8'h33, 1'b0, 9'h08D);
        expect_run(DIGITS);
        release_op(1'b0, 9'h08D);
`endif

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
